// File: rtl/ring_arb_pkg.sv
// ring_arb_pkg: shared state type, ring helpers and defaults for ring_rr_arbiter.
package ring_arb_pkg;

    typedef enum logic {IDLE, OWNED} state_t;

    localparam int MAX_HOLD_DEFAULT = 8;
    localparam int MAX_W = 32;

    // Helpers work on a fixed-width carrier; callers cast back to their own width.
    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) r[(i + 1) % w] = v[i];
        return r;
    endfunction

    function automatic int onehot_to_idx(input logic [MAX_W-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_W; i++)
            if (v[i]) idx = idx | i;
        return idx;
    endfunction

endpackage

// File: rtl/rr_select.sv
// rr_select: first set bit of req at or above the one-hot ptr position, wrapping around.
module rr_select #(
    parameter int width = 4
) (
    input  logic [width-1:0] req,
    input  logic [width-1:0] ptr,
    output logic [width-1:0] sel
);

    logic [2*width-1:0] dbl;
    logic [2*width-1:0] low;

    // Lower copy masked below ptr; the upper copy supplies the wrapped candidates.
    assign dbl = {req, req & ~(ptr - 1'b1)};
    assign low = dbl & ~(dbl - 1'b1);
    assign sel = low[width-1:0] | low[2*width-1:width];

endmodule

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with one-hot ring pointer and registered one-hot grant.
// Optional owner preemption after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int word_size = 4,
    parameter int MAX_HOLD  = MAX_HOLD_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [word_size-1:0]         req,
    output logic [word_size-1:0]         grant,
    output logic [$clog2(word_size)-1:0] grant_id,
    output logic                         busy
);

    localparam int IDW = $clog2(word_size);

    if (word_size < 2 || word_size > MAX_W || MAX_HOLD < 1) begin : g_bad_param
        $error("ring_rr_arbiter: illegal word_size or MAX_HOLD");
    end

    state_t               state;
    state_t               nxt_state;
    logic [word_size-1:0] ptr;
    logic [word_size-1:0] fresh;
    logic [word_size-1:0] others;
    logic [word_size-1:0] rot;
    logic [word_size-1:0] next;
    logic [word_size-1:0] nxt_grant;
    logic                 handoff;
    logic                 issue;
    logic                 timeout;

    rr_select #(.width(word_size)) u_fresh (.req(req),    .ptr(ptr), .sel(fresh));
    rr_select #(.width(word_size)) u_next  (.req(others), .ptr(rot), .sel(next));

    assign others = req & ~grant;
    assign rot    = word_size'(rotl1(MAX_W'(grant), word_size));
    assign busy   = |grant;

    // Handoff happens when the owner lets go, or when it is preempted.
    assign handoff   = state == OWNED && (!(|(req & grant)) || timeout);
    assign nxt_grant = state == IDLE ? fresh : (handoff ? next : grant);
    assign issue     = state == IDLE ? |req : (handoff && |next);
    assign nxt_state = |nxt_grant ? OWNED : IDLE;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold;
    assign timeout = hold == HW'(MAX_HOLD - 1) && |others;
    always_ff @(posedge clock) begin
        if (reset)
            hold <= '0;
        else if (enable)
            hold <= issue ? '0 : (state == OWNED && hold != HW'(MAX_HOLD - 1)) ? hold + 1'b1 : hold;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= word_size'(1);
        end else if (enable) begin
            state    <= nxt_state;
            grant    <= nxt_grant;
            grant_id <= IDW'(onehot_to_idx(MAX_W'(nxt_grant)));
            if (issue) ptr <= word_size'(rotl1(MAX_W'(nxt_grant), word_size));
        end
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter: directed checks of ring_rr_arbiter with word_size=4, MAX_HOLD=4.
module tb_ring_rr_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;

    int checks = 0;
    int errors = 0;

    ring_rr_arbiter #(.word_size(4), .MAX_HOLD(4)) dut (
        .clock(clock), .reset(reset), .enable(enable), .req(req),
        .grant(grant), .grant_id(grant_id), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] rot_exp [5];
        logic [3:0] to_exp;
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset with all requests pending
        reset = 1'b1; enable = 1'b1; req = 4'b1111;
        step(); step();
        check("rst_grant", grant, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_id", grant_id, 2'd0);
        check("rst_ptr", dut.ptr, 4'b0001);
        reset = 1'b0;
        step();
        check("first_grant", grant, 4'b0001);
        check("first_ptr", dut.ptr, 4'b0010);

        // Rotation: each owner holds two cycles, drops for one
        for (int i = 0; i < 4; i++) begin
            req = 4'b1111;
            step();
            check("rot_hold", grant, rot_exp[i]);
            req = 4'b1111 & ~rot_exp[i];
            step();
            check("rot_next", grant, rot_exp[i+1]);
            check("rot_busy", busy, 1'b1);
        end

        // Drain to idle, then park ptr at 1000 via a grant to bit 2
        req = 4'b0000; step();
        check("drain_grant", grant, 4'b0000);
        req = 4'b0100; step();
        check("park_grant", grant, 4'b0100);
        check("park_id", grant_id, 2'd2);
        req = 4'b0000; step();
        check("park_ptr", dut.ptr, 4'b1000);

        // Wrap and skip
        req = 4'b0101; step();
        check("wrap_grant", grant, 4'b0001);
        check("wrap_ptr", dut.ptr, 4'b0010);
        req = 4'b0100; step();
        check("skip_grant", grant, 4'b0100);
        req = 4'b0000; step();
        check("skip_idle", busy, 1'b0);

        // Single requester, release to idle
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            check("single_grant", grant, 4'b0010);
            check("single_id", grant_id, 2'd1);
        end
        req = 4'b0000; step();
        check("single_rel_grant", grant, 4'b0000);
        check("single_rel_busy", busy, 1'b0);
        check("single_rel_id", grant_id, 2'd0);

        // Enable freeze, then mid-grant reset
        req = 4'b0100; step();
        check("pre_freeze", grant, 4'b0100);
        enable = 1'b0; req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("freeze_grant", grant, 4'b0100);
            check("freeze_busy", busy, 1'b1);
        end
        enable = 1'b1; req = 4'b0100; reset = 1'b1;
        step();
        check("midrst_grant", grant, 4'b0000);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ptr", dut.ptr, 4'b0001);
        reset = 1'b0; req = 4'b0000;
        step();
        check("post_rst_idle", grant, 4'b0000);

        // Hold limit with two continuous requesters
        req = 4'b0011; step();
        check("to_first", grant, 4'b0001);
        for (int i = 1; i < 9; i++) begin
            step();
`ifdef ARB_TIMEOUT_EN
            to_exp = (i < 4) ? 4'b0001 : (i < 8) ? 4'b0010 : 4'b0001;
`else
            to_exp = 4'b0001;
`endif
            check("to_seq", grant, to_exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
